// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259-style PIC control logic.
//   - FSM state enum for the two-pulse INTA handshake
//   - read-select codes, OCW2 command encodings, ICW/OCW word numbers
//   - prio_rank(): priority rank of a level relative to the rotation pointer
// Optional feature macro: PIC_ROTATE_PRIO_EN (consumed by pic_control_logic).
package pic_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam int unsigned LVL_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK1 = 1'b1
    } state_e;

    typedef enum logic {
        RSEL_IRR = 1'b0,
        RSEL_ISR = 1'b1
    } rsel_e;

    // OCW2 bits[7:5]
    localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
    localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
    localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
    localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;
    localparam logic [2:0] OCW2_SET_PRIO   = 3'b110;

    // Word numbers carried on wr_nr
    localparam logic [1:0] ICW1_NR = 2'd0;
    localparam logic [1:0] ICW2_NR = 2'd1;
    localparam logic [1:0] ICW3_NR = 2'd2;
    localparam logic [1:0] ICW4_NR = 2'd3;
    localparam logic [1:0] OCW1_NR = 2'd0;
    localparam logic [1:0] OCW2_NR = 2'd1;
    localparam logic [1:0] OCW3_NR = 2'd2;

    // Rank 0 is the highest priority, i.e. level lp+1 (mod 8).
    function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] idx,
                                                   input logic [LVL_W-1:0] lp);
        return LVL_W'(idx - lp - 3'd1);
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: finds the highest-priority set bit of an 8-bit vector.
// Search order starts at lp_i+1 and wraps modulo 8.
//   vec_i   in  8  request/service vector
//   lp_i    in  3  lowest-priority level (rotation pointer)
//   valid_o out 1  any bit set
//   idx_o   out 3  winning level
module pic_priority_resolver (
    input  logic [7:0] vec_i,
    input  logic [2:0] lp_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (vec_i[3'(lp_i + 3'(k) + 3'd1)]) begin
                valid_o = 1'b1;
                idx_o   = 3'(lp_i + 3'(k) + 3'd1);
            end
        end
    end

endmodule

// File: rtl/pic_control_logic.sv
// pic_control_logic: control core of an 8259-style PIC. Holds ICW/OCW state,
// IRR/ISR/IMR and the priority pointer, runs the two-pulse INTA handshake and
// returns read-back data.
//   clk, rst            clock, synchronous active-high reset
//   wr_stb/type/nr/data decoded command-word write
//   a0                  read address bit (1: IMR, 0: IRR/ISR per OCW3)
//   ir                  interrupt request lines
//   inta                one-cycle pulse per INTA bus cycle
//   rd_data             registered read-back data
//   int_out             registered interrupt request to the CPU
//   vec_data/vec_valid  vector and its one-cycle strobe
// Macro PIC_ROTATE_PRIO_EN enables the OCW2 rotate / set-priority commands.
module pic_control_logic
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_stb,
    input  logic       wr_type,
    input  logic [1:0] wr_nr,
    input  logic [7:0] wr_data,
    input  logic       a0,
    input  logic [7:0] ir,
    input  logic       inta,
    output logic [7:0] rd_data,
    output logic       int_out,
    output logic [7:0] vec_data,
    output logic       vec_valid
);

    state_e     state_q, state_d;
    rsel_e      rsel_q, rsel_d;
    logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, ir_q;
    logic [2:0] lp_q, lp_d, lvl_q, lvl_d;
    logic [4:0] vbase_q, vbase_d;
    logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d, aeoi_q, aeoi_d;
    logic       init_done_q, init_done_d;
    logic [7:0] rd_data_q, rd_data_d, vec_data_q, vec_data_d;
    logic       int_out_q, int_out_d, vec_valid_q, vec_valid_d;

    logic       req_vld, isr_vld, req_c, icw1_wr, ack1, ack2;
    logic [2:0] req_idx, isr_idx;
    logic [7:0] isr_set, isr_clr, irr_clr;

    pic_priority_resolver u_req_res (
        .vec_i   (irr_q & ~imr_q),
        .lp_i    (lp_q),
        .valid_o (req_vld),
        .idx_o   (req_idx)
    );

    pic_priority_resolver u_isr_res (
        .vec_i   (isr_q),
        .lp_i    (lp_q),
        .valid_o (isr_vld),
        .idx_o   (isr_idx)
    );

    // A request must strictly outrank the highest level in service.
    assign req_c   = req_vld && (!isr_vld || (prio_rank(req_idx, lp_q) < prio_rank(isr_idx, lp_q)));
    assign icw1_wr = wr_stb && wr_type && (wr_nr == ICW1_NR);
    assign ack1    = inta && init_done_q && !icw1_wr && (state_q == ST_IDLE);
    assign ack2    = inta && init_done_q && !icw1_wr && (state_q == ST_ACK1);

    // Next-state logic for all registers.
    always_comb begin
        state_d     = state_q;
        rsel_d      = rsel_q;
        imr_d       = imr_q;
        lp_d        = lp_q;
        lvl_d       = lvl_q;
        vbase_d     = vbase_q;
        ltim_d      = ltim_q;
        sngl_d      = sngl_q;
        ic4_d       = ic4_q;
        aeoi_d      = aeoi_q;
        init_done_d = init_done_q;
        vec_data_d  = vec_data_q;
        vec_valid_d = 1'b0;
        isr_set     = 8'h00;
        isr_clr     = 8'h00;
        irr_clr     = 8'h00;

        // INTA handshake; no pending request means a spurious level 7.
        if (ack1) begin
            state_d = ST_ACK1;
            lvl_d   = req_c ? req_idx : 3'd7;
            if (req_c) begin
                isr_set[req_idx] = 1'b1;
                irr_clr[req_idx] = 1'b1;
            end
        end else if (ack2) begin
            state_d     = ST_IDLE;
            vec_data_d  = {vbase_q, lvl_q};
            vec_valid_d = 1'b1;
            if (aeoi_q) begin
                isr_clr[lvl_q] = 1'b1;
            end
        end

        if (wr_stb && wr_type) begin
            case (wr_nr)
                ICW2_NR: begin
                    vbase_d = wr_data[7:3];
                    if (sngl_q && !ic4_q) init_done_d = 1'b1;
                end
                ICW3_NR: if (!ic4_q) init_done_d = 1'b1;
                ICW4_NR: begin
                    aeoi_d      = wr_data[1];
                    init_done_d = 1'b1;
                end
                default: ;
            endcase
        end else if (wr_stb) begin
            case (wr_nr)
                OCW1_NR: imr_d = wr_data;
                OCW2_NR: begin
                    case (wr_data[7:5])
`ifdef PIC_ROTATE_PRIO_EN
                        OCW2_NS_EOI: if (isr_vld) isr_clr[isr_idx] = 1'b1;
                        OCW2_SP_EOI: isr_clr[wr_data[2:0]] = 1'b1;
                        OCW2_ROT_NS_EOI: if (isr_vld) begin
                            isr_clr[isr_idx] = 1'b1;
                            lp_d             = isr_idx;
                        end
                        OCW2_ROT_SP_EOI: begin
                            isr_clr[wr_data[2:0]] = 1'b1;
                            lp_d                  = wr_data[2:0];
                        end
                        OCW2_SET_PRIO: lp_d = wr_data[2:0];
`else
                        OCW2_NS_EOI, OCW2_ROT_NS_EOI: if (isr_vld) isr_clr[isr_idx] = 1'b1;
                        OCW2_SP_EOI, OCW2_ROT_SP_EOI: isr_clr[wr_data[2:0]] = 1'b1;
`endif
                        default: ;
                    endcase
                end
                OCW3_NR: if (wr_data[1]) rsel_d = rsel_e'(wr_data[0]);
                default: ;
            endcase
        end

        isr_d = (isr_q & ~isr_clr) | isr_set;
        // Ack clear first, so a same-cycle new edge keeps its bit.
        irr_d = ltim_q ? ir : ((irr_q & ~irr_clr) | (ir & ~ir_q));

        if (icw1_wr) begin
            irr_d       = 8'h00;
            isr_d       = 8'h00;
            imr_d       = 8'h00;
            init_done_d = 1'b0;
            lp_d        = 3'd7;
            rsel_d      = RSEL_IRR;
            state_d     = ST_IDLE;
            ltim_d      = wr_data[3];
            sngl_d      = wr_data[1];
            ic4_d       = wr_data[0];
        end

        int_out_d = init_done_q && (state_q == ST_IDLE) && !inta && !icw1_wr && req_c;
        rd_data_d = a0 ? imr_q : ((rsel_q == RSEL_ISR) ? isr_q : irr_q);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsel_q      <= RSEL_IRR;
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            imr_q       <= 8'h00;
            ir_q        <= 8'h00;
            lp_q        <= 3'd7;
            lvl_q       <= 3'd0;
            vbase_q     <= 5'd0;
            ltim_q      <= 1'b0;
            sngl_q      <= 1'b0;
            ic4_q       <= 1'b0;
            aeoi_q      <= 1'b0;
            init_done_q <= 1'b0;
            rd_data_q   <= 8'h00;
            int_out_q   <= 1'b0;
            vec_data_q  <= 8'h00;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsel_q      <= rsel_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            ir_q        <= ir;
            lp_q        <= lp_d;
            lvl_q       <= lvl_d;
            vbase_q     <= vbase_d;
            ltim_q      <= ltim_d;
            sngl_q      <= sngl_d;
            ic4_q       <= ic4_d;
            aeoi_q      <= aeoi_d;
            init_done_q <= init_done_d;
            rd_data_q   <= rd_data_d;
            int_out_q   <= int_out_d;
            vec_data_q  <= vec_data_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign int_out   = int_out_q;
    assign vec_data  = vec_data_q;
    assign vec_valid = vec_valid_q;

endmodule

// File: tb/tb_pic_control_logic.sv
// tb_pic_control_logic: directed and randomized checks of pic_control_logic
// against a level-based behavioural model of the PIC.
module tb_pic_control_logic;

    logic       clk, rst, wr_stb, wr_type, a0, inta;
    logic [1:0] wr_nr;
    logic [7:0] wr_data, ir;
    logic [7:0] rd_data, vec_data;
    logic       int_out, vec_valid;

    int n_tests = 0;
    int n_fail  = 0;

    pic_control_logic dut (
        .clk       (clk),
        .rst       (rst),
        .wr_stb    (wr_stb),
        .wr_type   (wr_type),
        .wr_nr     (wr_nr),
        .wr_data   (wr_data),
        .a0        (a0),
        .ir        (ir),
        .inta      (inta),
        .rd_data   (rd_data),
        .int_out   (int_out),
        .vec_data  (vec_data),
        .vec_valid (vec_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] m_irr, m_isr, m_imr, m_vbase, m_irprev, m_rd, m_vec;
    logic       m_ltim, m_sngl, m_ic4, m_aeoi, m_done, m_rsel, m_ack, m_int, m_vval;
    int         m_lp, m_lvl;

    // Highest-priority set level, scanning from lp+1 upward; -1 if none.
    function automatic int top_of(input logic [7:0] v, input int lp);
        for (int r = 0; r < 8; r++) begin
            if (v[(lp + 1 + r) % 8]) return (lp + 1 + r) % 8;
        end
        return -1;
    endfunction

    function automatic int rank_of(input int lvl, input int lp);
        return (lvl - lp - 1 + 16) % 8;
    endfunction

    task automatic model_update(input logic s_rst, input logic s_stb, input logic s_type,
                                input logic [1:0] s_nr, input logic [7:0] s_data,
                                input logic s_a0, input logic [7:0] s_ir, input logic s_inta);
        int rq, sv;
        bit pend, icw1;
        logic [7:0] clr, set, ackclr;
        if (s_rst) begin
            m_irr = 0; m_isr = 0; m_imr = 0; m_vbase = 0; m_irprev = 0; m_rd = 0; m_vec = 0;
            m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_aeoi = 0; m_done = 0; m_rsel = 0;
            m_ack = 0; m_int = 0; m_vval = 0; m_lp = 7; m_lvl = 0;
            return;
        end
        rq   = top_of(m_irr & ~m_imr, m_lp);
        sv   = top_of(m_isr, m_lp);
        pend = (rq >= 0) && (sv < 0 || rank_of(rq, m_lp) < rank_of(sv, m_lp));
        icw1 = s_stb && s_type && (s_nr == 2'd0);
        m_rd = s_a0 ? m_imr : (m_rsel ? m_isr : m_irr);
        m_int = m_done && !m_ack && !s_inta && !icw1 && pend;
        m_vval = 0; clr = 0; set = 0; ackclr = 0;
        if (m_done && s_inta && !icw1) begin
            if (!m_ack) begin
                m_lvl = pend ? rq : 7;
                if (pend) begin set[rq] = 1'b1; ackclr[rq] = 1'b1; end
                m_ack = 1;
            end else begin
                m_vec  = (m_vbase & 8'hF8) | 8'(m_lvl);
                m_vval = 1;
                if (m_aeoi) clr[m_lvl] = 1'b1;
                m_ack = 0;
            end
        end
        if (s_stb && s_type) begin
            if (s_nr == 2'd1) begin m_vbase = s_data; if (m_sngl && !m_ic4) m_done = 1; end
            if (s_nr == 2'd2 && !m_ic4) m_done = 1;
            if (s_nr == 2'd3) begin m_aeoi = s_data[1]; m_done = 1; end
        end else if (s_stb) begin
            if (s_nr == 2'd0) m_imr = s_data;
            if (s_nr == 2'd2 && s_data[1]) m_rsel = s_data[0];
            if (s_nr == 2'd1) begin
                case (s_data[7:5])
                    3'b001: if (sv >= 0) clr[sv] = 1'b1;
                    3'b011: clr[s_data[2:0]] = 1'b1;
`ifdef PIC_ROTATE_PRIO_EN
                    3'b101: if (sv >= 0) begin clr[sv] = 1'b1; m_lp = sv; end
                    3'b111: begin clr[s_data[2:0]] = 1'b1; m_lp = int'(s_data[2:0]); end
                    3'b110: m_lp = int'(s_data[2:0]);
`else
                    3'b101: if (sv >= 0) clr[sv] = 1'b1;
                    3'b111: clr[s_data[2:0]] = 1'b1;
`endif
                    default: ;
                endcase
            end
        end
        m_isr    = (m_isr & ~clr) | set;
        m_irr    = m_ltim ? s_ir : ((m_irr & ~ackclr) | (s_ir & ~m_irprev));
        m_irprev = s_ir;
        if (icw1) begin
            m_irr = 0; m_isr = 0; m_imr = 0; m_done = 0; m_lp = 7; m_rsel = 0; m_ack = 0;
            m_ltim = s_data[3]; m_sngl = s_data[1]; m_ic4 = s_data[0];
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        logic s_rst, s_stb, s_type, s_a0, s_inta;
        logic [1:0] s_nr;
        logic [7:0] s_data, s_ir;
        s_rst = rst; s_stb = wr_stb; s_type = wr_type; s_nr = wr_nr;
        s_data = wr_data; s_a0 = a0; s_ir = ir; s_inta = inta;
        @(posedge clk);
        model_update(s_rst, s_stb, s_type, s_nr, s_data, s_a0, s_ir, s_inta);
        #1;
        wr_stb = 1'b0;
        inta   = 1'b0;
        chk("int_out",   {7'd0, int_out},   {7'd0, m_int});
        chk("vec_valid", {7'd0, vec_valid}, {7'd0, m_vval});
        chk("vec_data",  vec_data, m_vec);
        chk("rd_data",   rd_data,  m_rd);
    endtask

    task automatic wr(input logic typ, input logic [1:0] nr, input logic [7:0] data);
        wr_stb = 1'b1; wr_type = typ; wr_nr = nr; wr_data = data;
        tick();
    endtask

    task automatic do_init(input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w4);
        wr(1'b1, 2'd0, w1);
        wr(1'b1, 2'd1, w2);
        wr(1'b1, 2'd3, w4);
    endtask

    task automatic pulse_ir(input logic [7:0] m);
        ir = m; tick();
        ir = 8'h00; tick();
    endtask

    task automatic ack(input string tag, input logic [7:0] exp_vec);
        inta = 1'b1; tick();
        chk({tag, "_int_drop"}, {7'd0, int_out}, 8'h00);
        inta = 1'b1; tick();
        chk({tag, "_vvalid"}, {7'd0, vec_valid}, 8'h01);
        chk({tag, "_vec"}, vec_data, exp_vec);
    endtask

    task automatic rand_phase(input int n);
        logic [2:0] codes [6];
        codes = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b110, 3'b000};
        for (int c = 0; c < n; c++) begin
            ir   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            a0   = 1'($urandom);
            inta = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 15))
                0: begin wr_stb = 1; wr_type = 0; wr_nr = 2'd0; wr_data = 8'($urandom) & 8'($urandom); end
                1: begin wr_stb = 1; wr_type = 0; wr_nr = 2'd1;
                         wr_data = {codes[$urandom_range(0, 5)], 2'b00, 3'($urandom)}; end
                2: begin wr_stb = 1; wr_type = 0; wr_nr = 2'd2; wr_data = 8'h08 | 8'($urandom_range(0, 3)); end
                default: ;
            endcase
            tick();
        end
        ir = 8'h00; a0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_stb = 0; wr_type = 0; wr_nr = 0; wr_data = 0; a0 = 0; ir = 0; inta = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rd", rd_data, 8'h00);
        chk("rst_int", {7'd0, int_out}, 8'h00);
        chk("rst_vec", vec_data, 8'h00);

        // Basic edge request, vector and latency
        do_init(8'h13, 8'h40, 8'h01);
        ir = 8'h08; tick(); ir = 8'h00;
        chk("lat_k1", {7'd0, int_out}, 8'h00);
        tick();
        chk("lat_k2", {7'd0, int_out}, 8'h01);
        ack("ir3", 8'h43);
        tick();
        chk("vvalid_one", {7'd0, vec_valid}, 8'h00);
        wr(1'b0, 2'd2, 8'h0B); tick();
        chk("isr_ir3", rd_data, 8'h08);
        wr(1'b0, 2'd1, 8'h20); tick();
        chk("ns_eoi", rd_data, 8'h00);

        // Masked level is skipped
        wr(1'b0, 2'd0, 8'h08);
        pulse_ir(8'h28);
        chk("mask_int", {7'd0, int_out}, 8'h01);
        ack("ir5", 8'h45);
        wr(1'b0, 2'd1, 8'h20); tick();
        chk("ns_eoi5", rd_data, 8'h00);

        // Lower-priority request blocked while IR2 in service
        pulse_ir(8'h04);
        ack("ir2", 8'h42);
        chk("isr_ir2", rd_data, 8'h04);
        pulse_ir(8'h40);
        chk("blocked_a", {7'd0, int_out}, 8'h00);
        tick();
        chk("blocked_b", {7'd0, int_out}, 8'h00);
        wr(1'b0, 2'd1, 8'h62);
        chk("sp_eoi_k1", {7'd0, int_out}, 8'h00);
        tick();
        chk("sp_eoi_k2", {7'd0, int_out}, 8'h01);
        ack("ir6", 8'h46);
        wr(1'b0, 2'd1, 8'h20);

        // Spurious acknowledge
        ack("spur", 8'h47);
        chk("spur_isr", rd_data, 8'h00);

        // Automatic EOI
        do_init(8'h13, 8'h40, 8'h03);
        pulse_ir(8'h02);
        ack("aeoi", 8'h41);
        wr(1'b0, 2'd2, 8'h0B); tick();
        chk("aeoi_isr", rd_data, 8'h00);

        // Level mode, init complete on ICW2 (SNGL, no IC4)
        wr(1'b1, 2'd0, 8'h1A);
        wr(1'b1, 2'd1, 8'h40);
        ir = 8'h10; tick(); tick();
        chk("lvl_int", {7'd0, int_out}, 8'h01);
        chk("lvl_irr", rd_data, 8'h10);
        ir = 8'h00; tick(); tick();
        chk("lvl_drop", {7'd0, int_out}, 8'h00);

        // Requests and INTA ignored until init completes
        wr(1'b1, 2'd0, 8'h13);
        pulse_ir(8'h01);
        chk("noinit_int", {7'd0, int_out}, 8'h00);
        inta = 1'b1; tick();
        inta = 1'b1; tick();
        chk("noinit_vv", {7'd0, vec_valid}, 8'h00);
        wr(1'b1, 2'd1, 8'h48);
        wr(1'b1, 2'd3, 8'h01);
        tick();
        chk("init_int", {7'd0, int_out}, 8'h01);
        ack("ir0", 8'h48);
        wr(1'b0, 2'd1, 8'h20);

        // Cascade without ICW4: init completes on ICW3
        wr(1'b1, 2'd0, 8'h10);
        pulse_ir(8'h80);
        wr(1'b1, 2'd1, 8'h50); tick();
        chk("icw3_wait", {7'd0, int_out}, 8'h00);
        wr(1'b1, 2'd2, 8'h00); tick();
        chk("icw3_done", {7'd0, int_out}, 8'h01);
        ack("ir7", 8'h57);
        wr(1'b0, 2'd1, 8'h20);

        // Reset in the middle of the handshake
        do_init(8'h13, 8'h40, 8'h01);
        pulse_ir(8'h01);
        inta = 1'b1; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_rd", rd_data, 8'h00);
        inta = 1'b1; tick();
        chk("mid_rst_vv", {7'd0, vec_valid}, 8'h00);
        tick();
        chk("mid_rst_vv2", {7'd0, vec_valid}, 8'h00);

`ifdef PIC_ROTATE_PRIO_EN
        do_init(8'h13, 8'h40, 8'h01);
        pulse_ir(8'h01);
        ack("rot_ir0", 8'h40);
        wr(1'b0, 2'd1, 8'hA0);
        pulse_ir(8'h03);
        ack("rot_ir1", 8'h41);
`endif

        // Randomized traffic, edge then level mode
        do_init(8'h13, 8'h40, 8'h01);
        rand_phase(400);
        do_init(8'h1B, 8'h88, 8'h01);
        rand_phase(400);
        do_init(8'h13, 8'hC0, 8'h03);
        rand_phase(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
